// File: rtl/fp_div_ieee.sv
// fp_div_ieee: sequential IEEE-754-style divider, radix-2 restoring, RNE rounding, subnormals flushed to zero.
// Latency: specials finish 2 cycles after the start cycle; normal operands finish MAN_W+4 cycles after it (27 for 8/23).
// Backpressure: start is taken only in IDLE (including the done cycle); while an operation runs, start is ignored.
// Ports: clk/rst (async, active-high); start/busy/done handshake; op_a/op_b {sign,exp,frac} in;
//        res out (held until the next completion); overflow/underflow/invalid/div_by_zero/inexact valid with done.
module fp_div_ieee #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  output logic                   busy,
  output logic                   done,
  input  logic [EXP_W+MAN_W:0]   op_a,
  input  logic [EXP_W+MAN_W:0]   op_b,
  output logic [EXP_W+MAN_W:0]   res,
  output logic                   overflow,
  output logic                   underflow,
  output logic                   invalid,
  output logic                   div_by_zero,
  output logic                   inexact
);

  localparam int W  = 1 + EXP_W + MAN_W;
  localparam int N  = MAN_W + 2;
  localparam int EW = EXP_W + 2;
  localparam int CW = $clog2(N);
  localparam logic [EW-1:0]    BIAS     = EW'((1 << (EXP_W - 1)) - 1);
  localparam logic [EW-1:0]    EMAX     = {2'b00, {EXP_W{1'b1}}};
  localparam logic [EW-1:0]    E_ONE    = EW'(1);
  localparam logic [EXP_W-1:0] EXP_ONES = '1;

  typedef enum logic [1:0] {S_IDLE, S_CHECK, S_DIV, S_ROUND} state_t;

  state_t           state_q, state_d;
  logic [W-1:0]     a_q, a_d, b_q, b_d, res_q, res_d;
  logic [MAN_W+1:0] rem_q, rem_d;
  logic [MAN_W:0]   quo_q, quo_d;   // quotient bits below the leading 1: MAN_W fraction bits + guard
  logic [EW-1:0]    e_q, e_d;       // two's complement, wide enough for under/overflow
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [4:0]       flg_q, flg_d;   // {overflow, underflow, invalid, div_by_zero, inexact}
  logic             done_q, done_d;

  // Operand fields come from the captured copies, which stay put for the whole operation.
  logic             sign_s;
  logic [EXP_W-1:0] exp_a, exp_b;
  logic [MAN_W-1:0] frac_a, frac_b;
  logic             zero_a, zero_b, inf_a, inf_b, nan_a, nan_b, snan_a, snan_b;

  assign sign_s = a_q[W-1] ^ b_q[W-1];
  assign exp_a  = a_q[W-2:MAN_W];
  assign exp_b  = b_q[W-2:MAN_W];
  assign frac_a = a_q[MAN_W-1:0];
  assign frac_b = b_q[MAN_W-1:0];
  assign zero_a = (exp_a == '0);
  assign zero_b = (exp_b == '0);
  assign inf_a  = (exp_a == EXP_ONES) && (frac_a == '0);
  assign inf_b  = (exp_b == EXP_ONES) && (frac_b == '0);
  assign nan_a  = (exp_a == EXP_ONES) && (frac_a != '0);
  assign nan_b  = (exp_b == EXP_ONES) && (frac_b != '0);
  assign snan_a = nan_a && !frac_a[MAN_W-1];
  assign snan_b = nan_b && !frac_b[MAN_W-1];

  logic [MAN_W:0]   ma, mb;
  logic [EW-1:0]    e_init;
  logic             a_lt_b;
  logic [MAN_W+1:0] rem_init, rem_first, rem_sub;
  logic             rem_ge;

  assign ma     = {1'b1, frac_a};
  assign mb     = {1'b1, frac_b};
  assign e_init = {2'b00, exp_a} - {2'b00, exp_b} + BIAS;
  assign a_lt_b = (ma < mb);
  // Pre-normalising the dividend puts the quotient in [1,2), so its leading bit is always 1.
  // That first subtraction is done here, during CHECK, leaving N-1 bits for the DIV loop.
  assign rem_init  = a_lt_b ? {ma, 1'b0} : {1'b0, ma};
  assign rem_first = rem_init - {1'b0, mb};
  assign rem_ge    = (rem_q >= {1'b0, mb});
  assign rem_sub   = rem_q - {1'b0, mb};

  logic           guard, sticky, round_up;
  logic [MAN_W:0] frac_rnd;   // MSB is the carry into the hidden bit
  logic [EW-1:0]  e_rnd;
  logic           ovf_rnd, unf_rnd;

  assign guard    = quo_q[0];
  assign sticky   = |rem_q;
  assign round_up = guard & (sticky | quo_q[1]);
  // The hidden bit is always 1, so a carry out of the fraction renormalises to 1.0: fraction 0, exponent +1.
  assign frac_rnd = {1'b0, quo_q[MAN_W:1]} + {{MAN_W{1'b0}}, round_up};
  assign e_rnd    = e_q + {{(EW-1){1'b0}}, frac_rnd[MAN_W]};
  assign ovf_rnd  = !e_rnd[EW-1] && (e_rnd >= EMAX);
  assign unf_rnd  = e_rnd[EW-1] || (e_rnd == '0);

  logic [W-1:0] qnan_w, inf_w, zero_w;
  assign qnan_w = {1'b0, EXP_ONES, 1'b1, {(MAN_W-1){1'b0}}};
  assign inf_w  = {sign_s, EXP_ONES, {MAN_W{1'b0}}};
  assign zero_w = {sign_s, {(W-1){1'b0}}};

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    e_d     = e_q;
    cnt_d   = cnt_q;
    flg_d   = flg_q;
    done_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          a_d     = op_a;
          b_d     = op_b;
          flg_d   = '0;
          state_d = S_CHECK;
        end
      end
      S_CHECK: begin
        done_d  = 1'b1;
        state_d = S_IDLE;
        if (nan_a || nan_b || (zero_a && zero_b) || (inf_a && inf_b)) begin
          res_d    = qnan_w;
          flg_d[2] = snan_a || snan_b || (zero_a && zero_b) || (inf_a && inf_b);
        end else if (inf_a) begin
          res_d = inf_w;
        end else if (zero_b) begin
          res_d    = inf_w;
          flg_d[1] = 1'b1;
        end else if (inf_b || zero_a) begin
          res_d = zero_w;
        end else begin
          done_d  = 1'b0;
          state_d = S_DIV;
          e_d     = a_lt_b ? (e_init - E_ONE) : e_init;
          rem_d   = rem_first << 1;
          quo_d   = '0;
          cnt_d   = '0;
        end
      end
      S_DIV: begin
        quo_d = {quo_q[MAN_W-1:0], rem_ge};
        rem_d = rem_ge ? (rem_sub << 1) : (rem_q << 1);
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(N - 2)) begin
          state_d = S_ROUND;
        end
      end
      S_ROUND: begin
        done_d  = 1'b1;
        state_d = S_IDLE;
        if (ovf_rnd) begin
          res_d = inf_w;
          flg_d = 5'b10001;
        end else if (unf_rnd) begin
          res_d = zero_w;
          flg_d = 5'b01001;
        end else begin
          res_d = {sign_s, e_rnd[EXP_W-1:0], frac_rnd[MAN_W-1:0]};
          flg_d = {4'b0000, guard | sticky};
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      e_q     <= '0;
      cnt_q   <= '0;
      flg_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      e_q     <= e_d;
      cnt_q   <= cnt_d;
      flg_q   <= flg_d;
      done_q  <= done_d;
    end
  end

  // busy stays up through the done cycle even though a new start is already taken there.
  assign busy        = (state_q != S_IDLE) || done_q;
  assign done        = done_q;
  assign res         = res_q;
  assign overflow    = flg_q[4];
  assign underflow   = flg_q[3];
  assign invalid     = flg_q[2];
  assign div_by_zero = flg_q[1];
  assign inexact     = flg_q[0];

endmodule

// File: tb/tb_fp_div_ieee.sv
module tb_fp_div_ieee;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [31:0] op_a = '0, op_b = '0, res;
  logic        busy, done, overflow, underflow, invalid, div_by_zero, inexact;
  logic        start64 = 1'b0;
  logic [63:0] a64 = '0, b64 = '0, res64;
  logic        busy64, done64, ov64, un64, inv64, dz64, ix64;

  int cyc = 0;
  int n_checks = 0;
  int n_fail = 0;

  typedef struct {
    logic [31:0] res;
    logic [4:0]  flg;
    int          acc;
    int          due;
  } exp_t;
  exp_t        pend[$];
  logic [31:0] last_res = '0;

  fp_div_ieee dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
    .op_a(op_a), .op_b(op_b), .res(res),
    .overflow(overflow), .underflow(underflow), .invalid(invalid),
    .div_by_zero(div_by_zero), .inexact(inexact)
  );

  fp_div_ieee #(.EXP_W(11), .MAN_W(52)) dut64 (
    .clk(clk), .rst(rst), .start(start64), .busy(busy64), .done(done64),
    .op_a(a64), .op_b(b64), .res(res64),
    .overflow(ov64), .underflow(un64), .invalid(inv64),
    .div_by_zero(dz64), .inexact(ix64)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  // Reference: exact integer division of the significands, then IEEE rounding rules.
  // flags = {overflow, underflow, invalid, div_by_zero, inexact}
  function automatic void model(input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] r, output logic [4:0] f, output bit special);
    logic [7:0] ea, eb;
    logic [22:0] fa, fb;
    bit za, zb, ia, ib, na, nb, sna, snb, s, g, st;
    longint unsigned ma, mb, num, qt, rm, sig;
    int e;
    ea = a[30:23]; eb = b[30:23]; fa = a[22:0]; fb = b[22:0];
    s = a[31] ^ b[31];
    za = (ea == 0); zb = (eb == 0);
    ia = (ea == 8'hFF) && (fa == 0); ib = (eb == 8'hFF) && (fb == 0);
    na = (ea == 8'hFF) && (fa != 0); nb = (eb == 8'hFF) && (fb != 0);
    sna = na && !fa[22]; snb = nb && !fb[22];
    f = '0; special = 1'b1;
    if (na || nb || (za && zb) || (ia && ib)) begin
      r = 32'h7FC00000;
      f[2] = sna || snb || (za && zb) || (ia && ib);
    end else if (ia) begin
      r = {s, 8'hFF, 23'd0};
    end else if (zb) begin
      r = {s, 8'hFF, 23'd0};
      f[1] = 1'b1;
    end else if (ib || za) begin
      r = {s, 31'd0};
    end else begin
      special = 1'b0;
      ma  = {40'd0, 1'b1, fa};
      mb  = {40'd0, 1'b1, fb};
      num = ma << 25;
      qt  = num / mb;
      rm  = num % mb;
      e   = int'(ea) - int'(eb) + 127;
      if (qt >= (64'd1 << 25)) begin
        sig = qt >> 2; g = qt[1]; st = qt[0] || (rm != 0);
      end else begin
        sig = qt >> 1; g = qt[0]; st = (rm != 0); e = e - 1;
      end
      if (g && (st || sig[0])) sig = sig + 1;
      if (sig == (64'd1 << 24)) begin
        sig = 64'd1 << 23;
        e = e + 1;
      end
      if (e >= 255) begin
        r = {s, 8'hFF, 23'd0}; f = 5'b10001;
      end else if (e <= 0) begin
        r = {s, 31'd0}; f = 5'b01001;
      end else begin
        r = {s, 8'(e), sig[22:0]}; f = {4'b0000, g || st};
      end
    end
  endfunction

  task automatic chk_model(input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] er, input logic [4:0] ef, input bit es);
    logic [31:0] r;
    logic [4:0] f;
    bit sp;
    model(a, b, r, f, sp);
    chk("model_res", 64'(r), 64'(er));
    chk("model_flags", 64'(f), 64'(ef));
    chk("model_special", 64'(sp), 64'(es));
  endtask

  // Single compare process: done/busy timing, result and flags against the model queue.
  always @(negedge clk) begin : cmp
    logic [31:0] r;
    logic [4:0] f;
    bit sp, exp_done, exp_busy;
    exp_t ent;
    if (rst) begin
      pend.delete();
      last_res = '0;
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_done", 64'(done), 64'd0);
      chk("rst_res", 64'(res), 64'd0);
      chk("rst_flags", 64'({overflow, underflow, invalid, div_by_zero, inexact}), 64'd0);
    end else begin
      exp_done = (pend.size() > 0) && (pend[0].due == cyc);
      exp_busy = (pend.size() > 0) && (cyc > pend[0].acc);
      chk("done", 64'(done), 64'(exp_done));
      chk("busy", 64'(busy), 64'(exp_busy));
      if (exp_done) begin
        chk("res", 64'(res), 64'(pend[0].res));
        chk("flags", 64'({overflow, underflow, invalid, div_by_zero, inexact}), 64'(pend[0].flg));
        last_res = pend[0].res;
        void'(pend.pop_front());
      end else begin
        chk("res_held", 64'(res), 64'(last_res));
      end
      if (start && pend.size() == 0) begin
        model(op_a, op_b, r, f, sp);
        ent.res = r;
        ent.flg = f;
        ent.acc = cyc;
        ent.due = cyc + (sp ? 2 : 27);
        pend.push_back(ent);
      end
    end
  end

  task automatic issue(input logic [31:0] a, input logic [31:0] b);
    @(posedge clk); #1;
    start = 1'b1; op_a = a; op_b = b;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (pend.size() != 0 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    chk("wait_idle_timeout", 64'(pend.size()), 64'd0);
  endtask

  function automatic logic [31:0] rnd_fp();
    int m;
    logic [7:0] e;
    logic [22:0] f;
    m = $urandom_range(0, 15);
    f = 23'($urandom);
    case (m)
      0: e = 8'h00;
      1: e = 8'hFF;
      2: begin e = 8'hFF; f = '0; end
      3: e = 8'($urandom_range(1, 4));
      4: e = 8'($urandom_range(250, 254));
      default: e = 8'($urandom_range(90, 165));
    endcase
    return {1'($urandom), e, f};
  endfunction

  logic [31:0] dir_a [10] = '{32'h40C00000, 32'h3F800000, 32'h3F800000, 32'h3F800000, 32'h80000000,
                              32'h7F800000, 32'h7F800001, 32'h7F000000, 32'h00800000, 32'h7FC00000};
  logic [31:0] dir_b [10] = '{32'h40000000, 32'h40400000, 32'h3F800000, 32'h00000000, 32'h00000000,
                              32'hC0000000, 32'h3F800000, 32'h00800000, 32'h40000000, 32'h3F800000};
  logic [31:0] dir_r [10] = '{32'h40400000, 32'h3EAAAAAB, 32'h3F800000, 32'h7F800000, 32'h7FC00000,
                              32'hFF800000, 32'h7FC00000, 32'h7F800000, 32'h00000000, 32'h7FC00000};
  logic [4:0]  dir_f [10] = '{5'b00000, 5'b00001, 5'b00000, 5'b00010, 5'b00100,
                              5'b00000, 5'b00100, 5'b10001, 5'b01001, 5'b00000};
  bit          dir_s [10] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};

  initial begin
    int due, c, n;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Hand-computed expectations pin the model, then the same vectors go through the DUT.
    for (int i = 0; i < 10; i++) chk_model(dir_a[i], dir_b[i], dir_r[i], dir_f[i], dir_s[i]);
    for (int i = 0; i < 10; i++) begin
      issue(dir_a[i], dir_b[i]);
      wait_idle();
    end

    // start while busy with other operands must be ignored
    issue(32'h40C00000, 32'h40000000);
    repeat (3) @(posedge clk);
    #1 start = 1'b1; op_a = 32'h3F800000; op_b = 32'h40400000;
    @(posedge clk); #1 start = 1'b0;
    wait_idle();

    // start in the done cycle is accepted
    issue(32'h3F800000, 32'h40400000);
    due = pend[0].due;
    while (cyc < due) begin @(posedge clk); #1; end
    start = 1'b1; op_a = 32'h40C00000; op_b = 32'h40000000;
    @(posedge clk); #1 start = 1'b0;
    chk("done_cycle_start_accepted", 64'(pend.size()), 64'd1);
    wait_idle();

    // reset in the middle of a division aborts it
    issue(32'h40C00000, 32'h40000000);
    repeat (9) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    repeat (40) @(posedge clk);
    #1;
    issue(32'h40C00000, 32'h40000000);
    wait_idle();

    // randomized operands
    for (int i = 0; i < 300; i++) begin
      issue(rnd_fp(), rnd_fp());
      wait_idle();
    end

    // double-precision instance: 6/2
    @(posedge clk); #1;
    start64 = 1'b1; a64 = 64'h4018000000000000; b64 = 64'h4000000000000000;
    c = cyc;
    @(posedge clk); #1 start64 = 1'b0;
    n = 0;
    while (!done64 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("lat64", 64'(cyc - c), 64'd56);
    chk("res64", res64, 64'h4008000000000000);
    chk("flags64", 64'({ov64, un64, inv64, dz64, ix64}), 64'd0);

    repeat (2) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
